// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: combinational decode of the fetched word, registered
// into an output slot backed by a one-entry skid slot so backpressure never drops a beat.
module decode_stage #(
  parameter int XLEN          = 32,
  parameter bit RESET_PC_ZERO = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      rd_addr,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [10:0]     opclass,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  typedef enum logic [3:0] {
    CL_R, CL_I, CL_IM, CL_S, CL_B, CL_JAL, CL_JALR, CL_LUI, CL_AUIPC, CL_FENCE, CL_SYSTEM
  } opclass_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_IM     = 7'b0000011;
  localparam logic [6:0] OP_S      = 7'b0100011;
  localparam logic [6:0] OP_B      = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [10:0]     opc;
    logic [XLEN-1:0] imm;
    logic            ill;
  } payload_t;

  payload_t dec;
  payload_t out_q, out_d;
  payload_t skid_q, skid_d;
  logic     out_valid_q, out_valid_d;
  logic     skid_valid_q, skid_valid_d;
  logic     accept, move;

  // Immediates held as signed values so the width cast sign-extends to XLEN.
  logic signed [11:0] imm_i, imm_s;
  logic signed [12:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [20:0] imm_j;

  assign imm_i = in_instr[31:20];
  assign imm_s = {in_instr[31:25], in_instr[11:7]};
  assign imm_b = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  // NOTE: every field gets a default before the case, so no path leaves a latch.
  always_comb begin
    dec     = '0;
    dec.pc  = in_pc;
    dec.rd  = in_instr[11:7];
    dec.rs1 = in_instr[19:15];
    dec.rs2 = in_instr[24:20];
    dec.f3  = in_instr[14:12];
    dec.f7  = in_instr[31:25];
    case (in_instr[6:0])
      OP_R:      dec.opc[CL_R] = 1'b1;
      OP_I:      begin dec.opc[CL_I]      = 1'b1; dec.imm = XLEN'(imm_i); end
      OP_IM:     begin dec.opc[CL_IM]     = 1'b1; dec.imm = XLEN'(imm_i); end
      OP_S:      begin dec.opc[CL_S]      = 1'b1; dec.imm = XLEN'(imm_s); end
      OP_B:      begin dec.opc[CL_B]      = 1'b1; dec.imm = XLEN'(imm_b); end
      OP_JAL:    begin dec.opc[CL_JAL]    = 1'b1; dec.imm = XLEN'(imm_j); end
      OP_JALR:   begin dec.opc[CL_JALR]   = 1'b1; dec.imm = XLEN'(imm_i); end
      OP_LUI:    begin dec.opc[CL_LUI]    = 1'b1; dec.imm = XLEN'(imm_u); end
      OP_AUIPC:  begin dec.opc[CL_AUIPC]  = 1'b1; dec.imm = XLEN'(imm_u); end
      OP_FENCE:  dec.opc[CL_FENCE] = 1'b1;
      OP_SYSTEM: begin dec.opc[CL_SYSTEM] = 1'b1; dec.imm = XLEN'(imm_i); end
      // Every mapped opcode ends in 2'b11, so this also catches compressed encodings.
      default:   dec.ill = 1'b1;
    endcase
  end

  assign in_ready = !skid_valid_q && !flush;
  assign accept   = in_valid && in_ready;
  assign move     = !out_valid_q || out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_d        = out_q;
    skid_d       = skid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (move && skid_valid_q) begin
      out_d        = skid_q;
      out_valid_d  = 1'b1;
      skid_valid_d = 1'b0;
    end else if (move) begin
      out_d        = dec;
      out_valid_d  = accept;
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers sample together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  generate
    if (RESET_PC_ZERO) begin : g_data_rst
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_q  <= '0;
          skid_q <= '0;
        end else begin
          out_q  <= out_d;
          skid_q <= skid_d;
        end
      end
    end else begin : g_data_norst
      // NOTE: payload registers may skip reset because the valids qualify them.
      always_ff @(posedge clk) begin
        out_q  <= out_d;
        skid_q <= skid_d;
      end
    end
  endgenerate

  assign out_valid = out_valid_q;
  assign out_pc    = out_q.pc;
  assign rd_addr   = out_q.rd;
  assign rs1_addr  = out_q.rs1;
  assign rs2_addr  = out_q.rs2;
  assign funct3    = out_q.f3;
  assign funct7    = out_q.f7;
  assign opclass   = out_q.opc;
  assign imm       = out_q.imm;
  assign illegal   = out_q.ill;

endmodule
